spike_count_classifier: RTL and testbench

- Final decision stage, directly downstream of the spiking network top; consumes the per-timestep 11-class spike counts it produces on pred_out.
- Accumulates counts over a fixed number of timesteps per inference, then runs a sequential argmax.
- Presents the winning class index on a valid/ready handshake.

---
 rtl/spike_count_classifier.sv | 216 +++++++++++++++++++++
 tb/tb_spike_count_classifier.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_count_classifier.sv
// spike_count_classifier
// Final decision stage after the spiking network. It sums per-timestep class
// spike counts over one inference, then scans the sums one class per cycle
// to find the winner and offers it on a valid/ready handshake.
//
// Optional feature macro: SPIKE_CLS_EARLY_EXIT_EN
//   When defined, accumulation ends early as soon as any saturated accumulator
//   reaches EXIT_THRESH after an accepted beat.
//   When undefined, exactly NUM_STEPS beats are consumed per inference.
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous active-low reset
//   go           start pulse, sampled only while idle
//   in_valid     in_counts carries a beat this cycle
//   in_counts    packed counts, class c at [c*CNT_W +: CNT_W]
//   in_ready     beat accepted when in_valid & in_ready
//   class_out    winning class index
//   max_count    accumulator value of the winner
//   no_spike     every accumulator was zero
//   class_valid  result valid
//   class_ready  result consumer ready
//   busy         high whenever not idle
module spike_count_classifier #(
    parameter int NUM_CLASSES = 11,
    parameter int CNT_W       = 8,
    parameter int ACC_W       = 16,
    parameter int NUM_STEPS   = 16,
    parameter int EXIT_THRESH = 200
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         go,
    input  logic                         in_valid,
    input  logic [NUM_CLASSES*CNT_W-1:0] in_counts,
    output logic                         in_ready,
    output logic [3:0]                   class_out,
    output logic [ACC_W-1:0]             max_count,
    output logic                         no_spike,
    output logic                         class_valid,
    input  logic                         class_ready,
    output logic                         busy
);

    localparam int STEP_W = $clog2(NUM_STEPS + 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] EXIT_LVL = ACC_W'(EXIT_THRESH);
`ifdef SPIKE_CLS_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Add a zero-extended count one bit wider than the accumulator, then clamp.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W + 1 - CNT_W){1'b0}}, b};
        if (sum[ACC_W]) begin
            return ACC_MAX;
        end else begin
            return sum[ACC_W-1:0];
        end
    endfunction

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q [NUM_CLASSES];
    logic [ACC_W-1:0]    acc_d [NUM_CLASSES];
    logic [ACC_W-1:0]    sum_s [NUM_CLASSES];
    logic [STEP_W-1:0]   step_q, step_d;
    logic [3:0]          idx_q, idx_d;
    logic [ACC_W-1:0]    best_q, best_d;
    logic [3:0]          best_idx_q, best_idx_d;
    logic [3:0]          class_out_q, class_out_d;
    logic [ACC_W-1:0]    max_count_q, max_count_d;
    logic                no_spike_q, no_spike_d;
    logic                in_ready_q, busy_q, class_valid_q;
    logic                exit_s;
    logic                take_s;
    logic [ACC_W-1:0]    best_nxt_s;
    logic [3:0]          best_idx_nxt_s;

    // Saturated candidate sums for the current beat and the early-exit test on them.
    always_comb begin
        exit_s = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            sum_s[c] = sat_add(acc_q[c], in_counts[c*CNT_W +: CNT_W]);
            if (EARLY_EXIT && (sum_s[c] >= EXIT_LVL)) begin
                exit_s = 1'b1;
            end else begin
                exit_s = exit_s;
            end
        end
    end

    // Running argmax: index 0 seeds the best, later indices replace it only when strictly greater.
    always_comb begin
        take_s = (idx_q == 4'd0) || (acc_q[idx_q] > best_q);
        if (take_s) begin
            best_nxt_s     = acc_q[idx_q];
            best_idx_nxt_s = idx_q;
        end else begin
            best_nxt_s     = best_q;
            best_idx_nxt_s = best_idx_q;
        end
    end

    // Next-state and datapath update for the IDLE/ACCUM/SCAN/HOLD sequence.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        step_d      = step_q;
        idx_d       = idx_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        class_out_d = class_out_q;
        max_count_d = max_count_q;
        no_spike_d  = no_spike_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_ACCUM;
                    acc_d   = '{default: '0};
                    step_d  = '0;
                    idx_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d  = sum_s;
                    step_d = step_q + STEP_W'(1);
                    if ((step_q == STEP_W'(NUM_STEPS - 1)) || exit_s) begin
                        state_d = ST_SCAN;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_SCAN: begin
                best_d     = best_nxt_s;
                best_idx_d = best_idx_nxt_s;
                if (idx_q == 4'(NUM_CLASSES - 1)) begin
                    class_out_d = best_idx_nxt_s;
                    max_count_d = best_nxt_s;
                    no_spike_d  = (best_nxt_s == '0);
                    idx_d       = 4'd0;
                    state_d     = ST_HOLD;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_SCAN;
                end
            end
            ST_HOLD: begin
                if (class_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            acc_q         <= '{default: '0};
            step_q        <= '0;
            idx_q         <= 4'd0;
            best_q        <= '0;
            best_idx_q    <= 4'd0;
            class_out_q   <= 4'd0;
            max_count_q   <= '0;
            no_spike_q    <= 1'b0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            class_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            step_q        <= step_d;
            idx_q         <= idx_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            class_out_q   <= class_out_d;
            max_count_q   <= max_count_d;
            no_spike_q    <= no_spike_d;
            in_ready_q    <= (state_d == ST_ACCUM);
            busy_q        <= (state_d != ST_IDLE);
            class_valid_q <= (state_d == ST_HOLD);
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign class_valid = class_valid_q;
    assign class_out   = class_out_q;
    assign max_count   = max_count_q;
    assign no_spike    = no_spike_q;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Randomized self-checking bench for spike_count_classifier. Two instances
// share the stimulus: one with the default 16-bit accumulators and one with
// 10-bit accumulators so saturation is exercised. A transaction-level model
// (sums, clamps, argmax over plain int arrays) sets the expected outputs and
// a negedge process compares every cycle.
module tb_spike_count_classifier;
    localparam int NC = 11;
    localparam int CW = 8;
    localparam int NS = 16;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 1023;
    localparam int THRESH = 200;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0, in_valid = 1'b0, class_ready = 1'b0;
    logic [NC*CW-1:0] in_counts = '0;
    logic in_ready_a, no_spike_a, class_valid_a, busy_a;
    logic in_ready_b, no_spike_b, class_valid_b, busy_b;
    logic [3:0] class_out_a, class_out_b;
    logic [15:0] max_count_a;
    logic [9:0]  max_count_b;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;
    int exp_ready = 0, exp_busy = 0, exp_valid = 0;
    int exp_cls_a = 0, exp_max_a = 0, exp_ns_a = 0;
    int exp_cls_b = 0, exp_max_b = 0, exp_ns_b = 0;
    int sum_a[NC], sum_b[NC];

    spike_count_classifier #(.NUM_CLASSES(NC), .CNT_W(CW), .ACC_W(16), .NUM_STEPS(NS), .EXIT_THRESH(THRESH)) dut_a (
        .clock(clock), .reset(reset), .go(go), .in_valid(in_valid), .in_counts(in_counts),
        .in_ready(in_ready_a), .class_out(class_out_a), .max_count(max_count_a), .no_spike(no_spike_a),
        .class_valid(class_valid_a), .class_ready(class_ready), .busy(busy_a));

    spike_count_classifier #(.NUM_CLASSES(NC), .CNT_W(CW), .ACC_W(10), .NUM_STEPS(NS), .EXIT_THRESH(THRESH)) dut_b (
        .clock(clock), .reset(reset), .go(go), .in_valid(in_valid), .in_counts(in_counts),
        .in_ready(in_ready_b), .class_out(class_out_b), .max_count(max_count_b), .no_spike(no_spike_b),
        .class_valid(class_valid_b), .class_ready(class_ready), .busy(busy_b));

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model expectations.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("in_ready_a", int'(in_ready_a), exp_ready);
            chk("busy_a", int'(busy_a), exp_busy);
            chk("valid_a", int'(class_valid_a), exp_valid);
            chk("class_a", int'(class_out_a), exp_cls_a);
            chk("max_a", int'(max_count_a), exp_max_a);
            chk("nospike_a", int'(no_spike_a), exp_ns_a);
            chk("in_ready_b", int'(in_ready_b), exp_ready);
            chk("busy_b", int'(busy_b), exp_busy);
            chk("valid_b", int'(class_valid_b), exp_valid);
            chk("class_b", int'(class_out_b), exp_cls_b);
            chk("max_b", int'(max_count_b), exp_max_b);
            chk("nospike_b", int'(no_spike_b), exp_ns_b);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int gen_cnt(input int mode, input int c);
        int r;
        case (mode)
            1: return (c == 7) ? 5 : 1;
            2: return (c == 2 || c == 5) ? 3 : 0;
            3: return 0;
            4: return (c == 4) ? 255 : 0;
            5: return (c == 1) ? 2 : 0;
            6: return (c == 9) ? 50 : 0;
            default: begin
                r = $urandom_range(0, 9);
                if (r < 6) return $urandom_range(0, 3);
                else if (r < 8) return $urandom_range(0, 40);
                else return 255;
            end
        endcase
    endfunction

    // Argmax with lowest-index tie-break over a set of sums.
    task automatic argmax(input int s[NC], output int cls, output int mx);
        cls = 0;
        mx = s[0];
        for (int c = 1; c < NC; c++) begin
            if (s[c] > mx) begin
                mx = s[c];
                cls = c;
            end
        end
    endtask

    // One full inference: start, feed beats, expect the scan latency, hold, handshake.
    task automatic run_inf(input int mode, input int hold_cycles, input bit go_in_hold);
        int beats;
        bit done;
        bit hit;
        int v;
        for (int c = 0; c < NC; c++) begin
            sum_a[c] = 0;
            sum_b[c] = 0;
        end
        beats = 0;
        done = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        exp_busy = 1;
        exp_ready = 1;
        while (!done) begin
            in_valid = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            for (int c = 0; c < NC; c++) begin
                v = gen_cnt(mode, c);
                in_counts[c*CW +: CW] = CW'(v);
            end
            tick();
            if (in_valid) begin
                hit = 1'b0;
                for (int c = 0; c < NC; c++) begin
                    v = int'(in_counts[c*CW +: CW]);
                    sum_a[c] = (sum_a[c] + v > MAX_A) ? MAX_A : sum_a[c] + v;
                    sum_b[c] = (sum_b[c] + v > MAX_B) ? MAX_B : sum_b[c] + v;
                    if (sum_a[c] >= THRESH) hit = 1'b1;
                end
                beats++;
`ifdef SPIKE_CLS_EARLY_EXIT_EN
                if (hit) done = 1'b1;
`endif
                if (beats == NS) done = 1'b1;
            end
        end
        exp_ready = 0;
        // Scan window: inputs toggle randomly and must be ignored.
        for (int i = 1; i <= NC; i++) begin
            in_valid = $urandom_range(0, 1);
            in_counts[CW-1:0] = CW'($urandom_range(0, 255));
            go = $urandom_range(0, 1);
            tick();
            if (i == NC) begin
                exp_valid = 1;
                argmax(sum_a, exp_cls_a, exp_max_a);
                argmax(sum_b, exp_cls_b, exp_max_b);
                exp_ns_a = (exp_max_a == 0) ? 1 : 0;
                exp_ns_b = (exp_max_b == 0) ? 1 : 0;
            end
        end
        in_valid = 1'b0;
        go = 1'b0;
        for (int k = 0; k < hold_cycles; k++) begin
            class_ready = 1'b0;
            go = go_in_hold && (k == 1);
            tick();
        end
        class_ready = 1'b1;
        go = go_in_hold;
        tick();
        exp_valid = 0;
        exp_busy = 0;
        class_ready = 1'b0;
        go = 1'b0;
        tick();
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 cmp_en = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();

        run_inf(1, 0, 1'b0);
        chk("t_class7_cls", int'(class_out_a), 7);
        chk("t_class7_max", int'(max_count_a), 80);
        chk("t_class7_ns", int'(no_spike_a), 0);

        run_inf(2, 1, 1'b0);
        chk("t_tie_cls", int'(class_out_a), 2);
        chk("t_tie_max", int'(max_count_a), 48);

        run_inf(3, 2, 1'b0);
        chk("t_zero_cls", int'(class_out_a), 0);
        chk("t_zero_max", int'(max_count_a), 0);
        chk("t_zero_ns", int'(no_spike_a), 1);

        run_inf(4, 0, 1'b0);
        chk("t_sat_cls", int'(class_out_b), 4);
`ifdef SPIKE_CLS_EARLY_EXIT_EN
        chk("t_sat_max", int'(max_count_b), 255);
`else
        chk("t_sat_max", int'(max_count_b), 1023);
        chk("t_wide_max", int'(max_count_a), 4080);
`endif

        // Long hold with a go pulse inside it and at the handshake.
        run_inf(1, 5, 1'b1);
        chk("t_hold_busy", int'(busy_a), 0);

        // Reset after 8 beats discards everything.
        go = 1'b1;
        tick();
        go = 1'b0;
        exp_busy = 1;
        exp_ready = 1;
        for (int b = 0; b < 8; b++) begin
            in_valid = 1'b1;
            for (int c = 0; c < NC; c++) in_counts[c*CW +: CW] = CW'(gen_cnt(1, c));
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        exp_busy = 0; exp_ready = 0; exp_valid = 0;
        exp_cls_a = 0; exp_max_a = 0; exp_ns_a = 0;
        exp_cls_b = 0; exp_max_b = 0; exp_ns_b = 0;
        chk("t_rst_busy", int'(busy_a), 0);
        chk("t_rst_max", int'(max_count_a), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_inf(5, 0, 1'b0);
        chk("t_after_rst_cls", int'(class_out_a), 1);
        chk("t_after_rst_max", int'(max_count_a), 32);

        run_inf(6, 0, 1'b0);
        chk("t_c9_cls", int'(class_out_a), 9);
`ifdef SPIKE_CLS_EARLY_EXIT_EN
        chk("t_c9_max", int'(max_count_a), 200);
`else
        chk("t_c9_max", int'(max_count_a), 800);
`endif

        for (int t = 0; t < 14; t++) begin
            run_inf(0, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
